pipelined_magnitude_comparator: RTL and testbench



---
 rtl/pipelined_magnitude_comparator.sv | 148 ++++++++++++++
 tb/tb_pipelined_magnitude_comparator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_magnitude_comparator.sv
`default_nettype none
// =============================================================================
// pipelined_magnitude_comparator
// MSB-first chunked LT/EQ/GT compare, one chunk per stage, global-stall flow.
// Revision 1.0
// =============================================================================
module pipelined_magnitude_comparator #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_lt,
   output logic             out_eq,
   output logic             out_gt,
   output logic [TAG_W-1:0] out_tag
);
   localparam int S  = int'((WIDTH + CHUNK - 1) / CHUNK);
   localparam int PW = S * int'(CHUNK);

   logic          en;
   logic [PW-1:0] a_pad;
   logic [PW-1:0] b_pad;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   always_comb begin
      a_pad              = '0;
      b_pad              = '0;
      a_pad[WIDTH-1:0]   = in_a;
      b_pad[WIDTH-1:0]   = in_b;
      a_pad[WIDTH-1]     = in_a[WIDTH-1] ^ in_signed;
      b_pad[WIDTH-1]     = in_b[WIDTH-1] ^ in_signed;
   end

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int IW = (S - k) * int'(CHUNK);

      logic [IW-1:0]    a_in;
      logic [IW-1:0]    b_in;
      logic             valid_in;
      logic             lt_in;
      logic             eq_in;
      logic             gt_in;
      logic [TAG_W-1:0] tag_in;
      logic [CHUNK-1:0] chunk_a;
      logic [CHUNK-1:0] chunk_b;
      logic             valid_d;
      logic             lt_d;
      logic             eq_d;
      logic             gt_d;
      logic [TAG_W-1:0] tag_d;
      logic             valid_q;
      logic             lt_q;
      logic             eq_q;
      logic             gt_q;
      logic [TAG_W-1:0] tag_q;

      if (k == 0) begin : g_head
         assign a_in     = a_pad;
         assign b_in     = b_pad;
         assign valid_in = in_valid;
         assign lt_in    = 1'b0;
         assign eq_in    = 1'b1;
         assign gt_in    = 1'b0;
         assign tag_in   = in_tag;
      end else begin : g_link
         assign a_in     = g_stage[k-1].g_mid.a_rem_q;
         assign b_in     = g_stage[k-1].g_mid.b_rem_q;
         assign valid_in = g_stage[k-1].valid_q;
         assign lt_in    = g_stage[k-1].lt_q;
         assign eq_in    = g_stage[k-1].eq_q;
         assign gt_in    = g_stage[k-1].gt_q;
         assign tag_in   = g_stage[k-1].tag_q;
      end

      assign chunk_a = a_in[IW-1 -: CHUNK];
      assign chunk_b = b_in[IW-1 -: CHUNK];

      // Once a more significant chunk has decided, lower chunks cannot override it.
      always_comb begin
         valid_d = valid_in;
         tag_d   = tag_in;
         lt_d    = lt_in;
         eq_d    = 1'b0;
         gt_d    = gt_in;
         if (eq_in) begin
            lt_d = (chunk_a <  chunk_b);
            eq_d = (chunk_a == chunk_b);
            gt_d = (chunk_a >  chunk_b);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            tag_q   <= '0;
         end else if (en) begin
            valid_q <= valid_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            tag_q   <= tag_d;
         end
      end

      if (k < S - 1) begin : g_mid
         logic [IW-CHUNK-1:0] a_rem_d;
         logic [IW-CHUNK-1:0] b_rem_d;
         logic [IW-CHUNK-1:0] a_rem_q;
         logic [IW-CHUNK-1:0] b_rem_q;

         always_comb begin
            a_rem_d = a_in[IW-CHUNK-1:0];
            b_rem_d = b_in[IW-CHUNK-1:0];
         end

         always_ff @(posedge clk) begin
            if (en) begin
               a_rem_q <= a_rem_d;
               b_rem_q <= b_rem_d;
            end
         end
      end
   end

   assign out_valid = g_stage[S-1].valid_q;
   assign out_lt    = g_stage[S-1].lt_q;
   assign out_eq    = g_stage[S-1].eq_q;
   assign out_gt    = g_stage[S-1].gt_q;
   assign out_tag   = g_stage[S-1].tag_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_magnitude_comparator.sv
`default_nettype none
// =============================================================================
// tb_pipelined_magnitude_comparator
// Two instances (32/8 and 12/5) checked against an integer compare model.
// Revision 1.0
// =============================================================================
module tb_pipelined_magnitude_comparator;
   localparam int W0 = 32;
   localparam int C0 = 8;
   localparam int S0 = 4;
   localparam int W1 = 12;
   localparam int C1 = 5;
   localparam int S1 = 3;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid  [2];
   logic          in_ready  [2];
   logic [31:0]   in_a      [2];
   logic [31:0]   in_b      [2];
   logic          in_signed [2];
   logic [TW-1:0] in_tag    [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic          out_lt    [2];
   logic          out_eq    [2];
   logic          out_gt    [2];
   logic [TW-1:0] out_tag   [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_magnitude_comparator #(.WIDTH(W0), .CHUNK(C0), .TAG_W(TW)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .in_signed(in_signed[0]), .in_tag(in_tag[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_lt(out_lt[0]), .out_eq(out_eq[0]), .out_gt(out_gt[0]), .out_tag(out_tag[0])
   );

   pipelined_magnitude_comparator #(.WIDTH(W1), .CHUNK(C1), .TAG_W(TW)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1][W1-1:0]), .in_b(in_b[1][W1-1:0]), .in_signed(in_signed[1]), .in_tag(in_tag[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_lt(out_lt[1]), .out_eq(out_eq[1]), .out_gt(out_gt[1]), .out_tag(out_tag[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: interpret operands as integers and compare them, returns {lt,eq,gt}.
   function automatic logic [2:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
      logic [31:0] mask;
      longint      sa;
      longint      sb;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      sa   = longint'(a & mask);
      sb   = longint'(b & mask);
      if (sgn) begin
         if (a[w-1]) sa = sa - (64'sd1 <<< w);
         if (b[w-1]) sb = sb - (64'sd1 <<< w);
      end
      return {sa < sb, sa == sb, sa > sb};
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case ($urandom_range(0, 5))
         0:       v = 32'h0;
         1:       v = 32'h1 << (w - 1);
         2:       v = mask;
         3:       v = mask >> 1;
         default: v = $urandom;
      endcase
      return v & mask;
   endfunction

   // Scoreboard per instance: handshakes are judged at negedge, just before the edge that acts on them.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int MW = (g == 0) ? W0 : W1;
      logic [6:0] q [$];
      logic       stalled = 1'b0;
      logic [7:0] held;
      logic [6:0] exp;

      always @(negedge clk) begin
         if (rst) begin
            q.delete();
            stalled = 1'b0;
         end else begin
            check($sformatf("in_ready%0d", g), 64'(in_ready[g]), 64'(!out_valid[g] || out_ready[g]));
            if (stalled)
               check($sformatf("hold%0d", g),
                     64'({out_valid[g], out_lt[g], out_eq[g], out_gt[g], out_tag[g]}), 64'(held));
            if (out_valid[g]) begin
               check($sformatf("onehot%0d", g),
                     64'(int'(out_lt[g]) + int'(out_eq[g]) + int'(out_gt[g])), 64'd1);
               if (out_ready[g]) begin
                  if (q.size() == 0) begin
                     check($sformatf("unexpected%0d", g), 64'd1, 64'd0);
                  end else begin
                     exp = q.pop_front();
                     check($sformatf("result%0d", g),
                           64'({out_lt[g], out_eq[g], out_gt[g], out_tag[g]}), 64'(exp));
                  end
               end
            end
            stalled = out_valid[g] && !out_ready[g];
            held    = {out_valid[g], out_lt[g], out_eq[g], out_gt[g], out_tag[g]};
            if (in_valid[g] && in_ready[g])
               q.push_back({model(MW, in_a[g], in_b[g], in_signed[g]), in_tag[g]});
         end
      end
   end

   task automatic run_one(input int g, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [TW-1:0] tag, input logic [2:0] exp, input string name);
      int t;
      in_a[g] = a; in_b[g] = b; in_signed[g] = sgn; in_tag[g] = tag; in_valid[g] = 1'b1;
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      t = 0;
      while (!out_valid[g] && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check({name, "_lat"}, 64'(t), 64'((g == 0 ? S0 : S1) - 1));
      check(name, 64'({out_lt[g], out_eq[g], out_gt[g], out_tag[g]}), 64'({exp, tag}));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int cyc;
      int seen;
      logic fire;
      for (int g = 0; g < 2; g++) begin
         in_valid[g] = 1'b0; out_ready[g] = 1'b1; in_a[g] = '0; in_b[g] = '0;
         in_signed[g] = 1'b0; in_tag[g] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_valid", 64'(out_valid[0]), 64'd0);
      check("rst_flags", 64'({out_lt[0], out_eq[0], out_gt[0]}), 64'd0);
      check("rst_tag",   64'(out_tag[0]), 64'd0);
      check("rst_ready", 64'(in_ready[0]), 64'd1);
      check("rst_valid1", 64'(out_valid[1]), 64'd0);

      run_one(0, 32'h0000_0100, 32'h0000_00FF, 1'b0, 4'd3, 3'b001, "u_gt_small");
      run_one(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4'd5, 3'b001, "u_gt_msb");
      run_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4'd6, 3'b100, "s_neg1_lt_1");
      run_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd7, 3'b001, "u_max_gt_1");
      run_one(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd9, 3'b100, "s_min_lt_neg1");
      run_one(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'hA, 3'b010, "eq");
      run_one(0, 32'h1234_5678, 32'h1234_5679, 1'b0, 4'hB, 3'b100, "lsb_lt");
      run_one(1, 32'h800, 32'h7FF, 1'b1, 4'hC, 3'b100, "rag_s_lt");
      run_one(1, 32'h800, 32'h7FF, 1'b0, 4'hD, 3'b001, "rag_u_gt");

      // Six back-to-back transactions with a three-cycle output stall in the middle.
      sent = 0;
      cyc  = 0;
      while (sent < 6 && cyc < 50) begin
         out_ready[0] = !(cyc >= 4 && cyc < 7);
         in_valid[0]  = 1'b1;
         in_a[0]      = $urandom;
         in_b[0]      = ($urandom_range(0, 2) == 0) ? in_a[0] : $urandom;
         in_signed[0] = 1'($urandom_range(0, 1));
         in_tag[0]    = 4'(sent);
         #1;
         fire = in_ready[0];
         @(posedge clk); #1;
         if (fire) sent++;
         cyc++;
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      check("bp_sent", 64'(sent), 64'd6);
      check("bp_stalled", 64'(cyc > 6), 64'd1);
      repeat (10) @(posedge clk);
      #1 check("bp_drain", 64'(g_mon[0].q.size()), 64'd0);

      // Three in flight, then reset: none may surface.
      for (int i = 0; i < 3; i++) begin
         in_valid[0] = 1'b1; in_a[0] = $urandom; in_b[0] = $urandom;
         in_signed[0] = 1'b0; in_tag[0] = 4'(8 + i);
         @(posedge clk); #1;
      end
      in_valid[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_valid", 64'(out_valid[0]), 64'd0);
      check("midrst_flags", 64'({out_lt[0], out_eq[0], out_gt[0]}), 64'd0);
      check("midrst_tag",   64'(out_tag[0]), 64'd0);
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid[0]) seen++;
      end
      check("midrst_ghost", 64'(seen), 64'd0);
      run_one(0, 32'h0000_0002, 32'h0000_0001, 1'b0, 4'hE, 3'b001, "post_rst");

      // Random traffic on both instances.
      for (int c = 0; c < 10000; c++) begin
         for (int g = 0; g < 2; g++) begin
            in_valid[g]  = ($urandom_range(0, 3) != 0);
            out_ready[g] = ($urandom_range(0, 3) != 0);
            in_a[g]      = pick(g == 0 ? W0 : W1);
            in_b[g]      = ($urandom_range(0, 3) == 0) ? in_a[g] : pick(g == 0 ? W0 : W1);
            in_signed[g] = 1'($urandom_range(0, 1));
            in_tag[g]    = 4'($urandom);
         end
         @(posedge clk); #1;
      end
      for (int g = 0; g < 2; g++) begin
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b1;
      end
      repeat (20) @(posedge clk);
      #1;
      check("drain0", 64'(g_mon[0].q.size()), 64'd0);
      check("drain1", 64'(g_mon[1].q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
